// File: rtl/leb128_encoder_pkg.sv
// leb128_encoder_pkg
//   Shared definitions for the LEB128 encoder: FSM state encoding and the
//   longest legal encodings for 32-bit and 64-bit operands.
package leb128_encoder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // ceil(32/7) and ceil(64/7) bytes
    localparam int unsigned MAX_LEN_32 = 5;
    localparam int unsigned MAX_LEN_64 = 10;

endpackage

// File: rtl/leb128_encoder_if.sv
// leb128_encoder_if
//   Request/response bundle of the LEB128 encoder.
//   Request side : in_valid, in_ready, in_data[63:0], in_signed, in_is64
//   Byte stream  : out_valid, out_ready, out_byte[7:0], out_last, out_index[3:0]
//   Status       : err (one-cycle pulse on a rejected request)
//   slave  = the encoder, master = the requester / byte consumer.
interface leb128_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_signed;
    logic        in_is64;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic [3:0]  out_index;
    logic        err;

    modport slave (
        input  in_valid, in_data, in_signed, in_is64, out_ready,
        output in_ready, out_valid, out_byte, out_last, out_index, err
    );

    modport master (
        output in_valid, in_data, in_signed, in_is64, out_ready,
        input  in_ready, out_valid, out_byte, out_last, out_index, err
    );

endinterface

// File: rtl/leb128_encoder.sv
// leb128_encoder
//   Serialises one 32- or 64-bit operand into its ULEB128 or SLEB128 byte
//   sequence, one byte per accepted output handshake.
//   Ports:
//     clk    - single clock, rising edge
//     reset  - synchronous, active-high
//     bus    - leb128_encoder_if.slave (request in, byte stream out, err)
//   Parameter:
//     USE_64B - 1 allows 64-bit operands; 0 rejects them with an err pulse.
module leb128_encoder #(
    parameter bit USE_64B = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    leb128_encoder_if.slave        bus
);
    import leb128_encoder_pkg::*;

    state_t             state_q, state_d;
    logic signed [63:0] work_q, work_d;
    logic               sgn_q, sgn_d;
    logic               is64_q, is64_d;
    logic [3:0]         idx_q, idx_d;
    logic               err_q, err_d;

    logic               term_last;
    logic [3:0]         max_idx;

    // Widen the operand to the 64-bit working register.
    function automatic logic signed [63:0] latch_operand(
        input logic [63:0] d,
        input logic        sgn,
        input logic        w64
    );
        if (w64)
            return $signed(d);
        else if (sgn)
            return $signed({{32{d[31]}}, d[31:0]});
        else
            return $signed({32'b0, d[31:0]});
    endfunction

    function automatic logic signed [63:0] shift7(
        input logic signed [63:0] w,
        input logic               sgn
    );
        return sgn ? (w >>> 7) : (w >> 7);
    endfunction

    // The current byte is final once the remaining bits carry no information:
    // unsigned -> nothing left; signed -> rest is pure sign and bit 6 already
    // shows that sign to the decoder.
    function automatic logic is_last(
        input logic signed [63:0] w,
        input logic               sgn
    );
        logic signed [63:0] sh;
        sh = w >>> 7;
        if (sgn)
            return ((sh == '0) && !w[6]) || ((&sh) && w[6]);
        else
            return (w >> 7) == '0;
    endfunction

    assign max_idx   = is64_q ? 4'(MAX_LEN_64 - 1) : 4'(MAX_LEN_32 - 1);
    // Length cap is a backstop; the termination rule already ends in range.
    assign term_last = is_last(work_q, sgn_q) || (idx_q == max_idx);

    // State register: control flops reset, datapath flops free-running.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
        work_q <= work_d;
        sgn_q  <= sgn_d;
        is64_q <= is64_d;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        sgn_d   = sgn_q;
        is64_d  = is64_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_is64 && !USE_64B) begin
                        // Consumed but not encoded.
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_EMIT;
                        sgn_d   = bus.in_signed;
                        is64_d  = bus.in_is64 & USE_64B;
                        idx_d   = '0;
                        work_d  = latch_operand(bus.in_data, bus.in_signed,
                                                bus.in_is64 & USE_64B);
                    end
                end
            end
            ST_EMIT: begin
                if (bus.out_ready) begin
                    if (term_last) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        work_d = shift7(work_q, sgn_q);
                        idx_d  = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs; reset masks everything so no byte escapes in the reset cycle.
    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE) && !reset;
        bus.out_valid = 1'b0;
        bus.out_byte  = '0;
        bus.out_last  = 1'b0;
        bus.out_index = reset ? 4'd0 : idx_q;
        bus.err       = err_q && !reset;
        if ((state_q == ST_EMIT) && !reset) begin
            bus.out_valid = 1'b1;
            bus.out_last  = term_last;
            bus.out_byte  = {~term_last, work_q[6:0]};
        end
    end

endmodule

// File: tb/tb_leb128_encoder.sv
module tb_leb128_encoder;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   sel   = 1'b0;   // 0: 64-bit-capable DUT, 1: 32-bit-only DUT
    int   checks = 0;
    int   errors = 0;

    leb128_encoder_if if_a ();
    leb128_encoder_if if_b ();

    leb128_encoder #(.USE_64B(1'b1)) dut64 (.clk(clk), .reset(reset), .bus(if_a));
    leb128_encoder #(.USE_64B(1'b0)) dut32 (.clk(clk), .reset(reset), .bus(if_b));

    always #5 clk = ~clk;

    logic       m_out_valid, m_out_last, m_in_ready, m_err;
    logic [7:0] m_out_byte;
    logic [3:0] m_out_index;
    assign m_out_valid = sel ? if_b.out_valid : if_a.out_valid;
    assign m_out_last  = sel ? if_b.out_last  : if_a.out_last;
    assign m_in_ready  = sel ? if_b.in_ready  : if_a.in_ready;
    assign m_err       = sel ? if_b.err       : if_a.err;
    assign m_out_byte  = sel ? if_b.out_byte  : if_a.out_byte;
    assign m_out_index = sel ? if_b.out_index : if_a.out_index;

    logic [7:0] cap_b [16];
    logic [3:0] cap_i [16];
    logic       cap_l [16];
    int         cap_n;
    logic       cap_to;
    logic       cap_rdy;

    typedef struct {
        logic [63:0] d;
        logic        s;
        logic        w;
        int          n;
        logic [79:0] b;   // byte k at [8k+7:8k]
    } vec_t;

    task automatic drive_idle();
        if_a.in_valid = 1'b0; if_b.in_valid = 1'b0;
        if_a.in_data = '0;    if_b.in_data = '0;
        if_a.in_signed = 1'b0; if_b.in_signed = 1'b0;
        if_a.in_is64 = 1'b0;  if_b.in_is64 = 1'b0;
        if_a.out_ready = 1'b0; if_b.out_ready = 1'b0;
    endtask

    // Present one request for one cycle; returns at the negedge where the
    // first byte should be visible.
    task automatic issue(input logic [63:0] d, input logic s, input logic w);
        @(negedge clk);
        if_a.in_data = d;   if_b.in_data = d;
        if_a.in_signed = s; if_b.in_signed = s;
        if_a.in_is64 = w;   if_b.in_is64 = w;
        if_a.out_ready = 1'b1; if_b.out_ready = 1'b1;
        if (sel) if_b.in_valid = 1'b1; else if_a.in_valid = 1'b1;
        @(negedge clk);
        if_a.in_valid = 1'b0; if_b.in_valid = 1'b0;
    endtask

    // Record bytes until out_last is consumed or the budget runs out.
    task automatic capture();
        cap_n = 0; cap_to = 1'b1; cap_rdy = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (m_out_valid) begin
                if (cap_n < 16) begin
                    cap_b[cap_n] = m_out_byte;
                    cap_i[cap_n] = m_out_index;
                    cap_l[cap_n] = m_out_last;
                end
                cap_n++;
                if (m_out_last) begin
                    cap_rdy = m_in_ready;
                    cap_to  = 1'b0;
                    @(negedge clk);
                    break;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic run_encode(input logic [63:0] d, input logic s, input logic w);
        issue(d, s, w);
        capture();
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++; if (if_a.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", if_a.in_ready); end
        checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", if_a.out_valid); end
        checks++; if (if_a.out_byte !== 8'h00) begin errors++; $display("FAIL rst_out_byte got %02h want 00", if_a.out_byte); end
        checks++; if (if_a.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b want 0", if_a.out_last); end
        checks++; if (if_a.out_index !== 4'd0) begin errors++; $display("FAIL rst_out_index got %0d want 0", if_a.out_index); end
        checks++; if (if_a.err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", if_a.err); end
        reset = 1'b0;
        #1;
        checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready64 got %b want 1", if_a.in_ready); end
        checks++; if (if_b.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready32 got %b want 1", if_b.in_ready); end
        checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL rst_release_valid got %b want 0", if_a.out_valid); end
    endtask

    task automatic test_encode();
        vec_t v [12];
        v[0]  = '{64'd624485,                 1'b0, 1'b0, 3,  80'h26_8E_E5};
        v[1]  = '{64'h0000_0000_FFFE_1DC0,    1'b1, 1'b0, 3,  80'h78_BB_C0};
        v[2]  = '{64'hDEAD_BEEF_FFFF_FFFF,    1'b1, 1'b0, 1,  80'h7F};
        v[3]  = '{64'd0,                      1'b0, 1'b0, 1,  80'h00};
        v[4]  = '{64'hFFFF_FFFF_0000_0080,    1'b0, 1'b0, 2,  80'h01_80};
        v[5]  = '{64'h0000_0000_FFFF_FFFF,    1'b0, 1'b0, 5,  80'h0F_FF_FF_FF_FF};
        v[6]  = '{64'hFFFF_FFFF_FFFF_FFFF,    1'b0, 1'b1, 10, 80'h01_FF_FF_FF_FF_FF_FF_FF_FF_FF};
        v[7]  = '{64'h8000_0000_0000_0000,    1'b1, 1'b1, 10, 80'h7F_80_80_80_80_80_80_80_80_80};
        v[8]  = '{64'd64,                     1'b1, 1'b1, 2,  80'h00_C0};
        v[9]  = '{64'h0000_0000_FFFF_FFC0,    1'b1, 1'b0, 1,  80'h40};
        v[10] = '{64'h0000_0000_7FFF_FFFF,    1'b1, 1'b0, 5,  80'h07_FF_FF_FF_FF};
        v[11] = '{64'd63,                     1'b1, 1'b1, 1,  80'h3F};
        sel = 1'b0;
        for (int i = 0; i < 12; i++) begin
            run_encode(v[i].d, v[i].s, v[i].w);
            checks++; if (cap_to !== 1'b0) begin errors++; $display("FAIL enc%0d_timeout got %0d bytes want %0d", i, cap_n, v[i].n); end
            checks++; if (cap_n != v[i].n) begin errors++; $display("FAIL enc%0d_len got %0d want %0d", i, cap_n, v[i].n); end
            for (int k = 0; k < v[i].n; k++) begin
                checks++; if (cap_b[k] !== v[i].b[k*8 +: 8]) begin errors++; $display("FAIL enc%0d_byte%0d got %02h want %02h", i, k, cap_b[k], v[i].b[k*8 +: 8]); end
                checks++; if (cap_i[k] !== 4'(k)) begin errors++; $display("FAIL enc%0d_index%0d got %0d want %0d", i, k, cap_i[k], k); end
                checks++; if (cap_l[k] !== (k == v[i].n - 1)) begin errors++; $display("FAIL enc%0d_last%0d got %b want %b", i, k, cap_l[k], (k == v[i].n - 1)); end
            end
            checks++; if (cap_rdy !== 1'b0) begin errors++; $display("FAIL enc%0d_ready_on_last got %b want 0", i, cap_rdy); end
            checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL enc%0d_ready_after got %b want 1", i, m_in_ready); end
        end
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        issue(64'd624485, 1'b0, 1'b0);
        checks++; if (m_out_byte !== 8'hE5) begin errors++; $display("FAIL bp_first got %02h want E5", m_out_byte); end
        @(negedge clk);
        if_a.out_ready = 1'b0;
        for (int h = 0; h < 4; h++) begin
            checks++; if (m_out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d_valid got %b want 1", h, m_out_valid); end
            checks++; if (m_out_byte !== 8'h8E) begin errors++; $display("FAIL bp_hold%0d_byte got %02h want 8E", h, m_out_byte); end
            checks++; if (m_out_last !== 1'b0) begin errors++; $display("FAIL bp_hold%0d_last got %b want 0", h, m_out_last); end
            checks++; if (m_out_index !== 4'd1) begin errors++; $display("FAIL bp_hold%0d_index got %0d want 1", h, m_out_index); end
            if (h < 3) @(negedge clk);
        end
        if_a.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (m_out_byte !== 8'h26) begin errors++; $display("FAIL bp_resume_byte got %02h want 26", m_out_byte); end
        checks++; if (m_out_last !== 1'b1) begin errors++; $display("FAIL bp_resume_last got %b want 1", m_out_last); end
        checks++; if (m_out_index !== 4'd2) begin errors++; $display("FAIL bp_resume_index got %0d want 2", m_out_index); end
        @(negedge clk);
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL bp_done_valid got %b want 0", m_out_valid); end
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL bp_done_ready got %b want 1", m_in_ready); end
    endtask

    task automatic test_reject();
        sel = 1'b1;
        @(negedge clk);
        if_b.in_data = 64'h1234_5678_9ABC_DEF0;
        if_b.in_signed = 1'b0;
        if_b.in_is64 = 1'b1;
        if_b.out_ready = 1'b1;
        if_b.in_valid = 1'b1;
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL rej_ready_req got %b want 1", m_in_ready); end
        @(negedge clk);
        if_b.in_valid = 1'b0;
        if_b.in_is64 = 1'b0;
        checks++; if (m_err !== 1'b1) begin errors++; $display("FAIL rej_err_pulse got %b want 1", m_err); end
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL rej_valid got %b want 0", m_out_valid); end
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL rej_ready got %b want 1", m_in_ready); end
        @(negedge clk);
        checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL rej_err_clear got %b want 0", m_err); end
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL rej_valid_after got %b want 0", m_out_valid); end
        run_encode(64'd624485, 1'b0, 1'b0);
        checks++; if (cap_n != 3) begin errors++; $display("FAIL rej_enc32_len got %0d want 3", cap_n); end
        checks++; if ({cap_b[0], cap_b[1], cap_b[2]} !== 24'hE5_8E_26) begin errors++; $display("FAIL rej_enc32_bytes got %02h %02h %02h want E5 8E 26", cap_b[0], cap_b[1], cap_b[2]); end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        issue(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++; if (m_out_index !== 4'd2) begin errors++; $display("FAIL rmid_pre_index got %0d want 2", m_out_index); end
        reset = 1'b1;
        #1;
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid_in_reset got %b want 0", m_out_valid); end
        checks++; if (m_in_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_reset got %b want 0", m_in_ready); end
        @(negedge clk);
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid_after got %b want 0", m_out_valid); end
        checks++; if (m_out_index !== 4'd0) begin errors++; $display("FAIL rmid_index_after got %0d want 0", m_out_index); end
        checks++; if (m_out_byte !== 8'h00) begin errors++; $display("FAIL rmid_byte_after got %02h want 00", m_out_byte); end
        reset = 1'b0;
        #1;
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_release got %b want 1", m_in_ready); end
        checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_more_bytes got %b want 0", m_out_valid); end
        run_encode(64'd624485, 1'b0, 1'b0);
        checks++; if (cap_n != 3) begin errors++; $display("FAIL rmid_new_len got %0d want 3", cap_n); end
        checks++; if ({cap_b[0], cap_b[1], cap_b[2]} !== 24'hE5_8E_26) begin errors++; $display("FAIL rmid_new_bytes got %02h %02h %02h want E5 8E 26", cap_b[0], cap_b[1], cap_b[2]); end
        checks++; if ({cap_i[0], cap_i[1], cap_i[2]} !== {4'd0, 4'd1, 4'd2}) begin errors++; $display("FAIL rmid_new_index got %0d %0d %0d want 0 1 2", cap_i[0], cap_i[1], cap_i[2]); end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_encode();
        test_backpressure();
        test_reject();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/leb128_encoder.md
LEB128_ENCODER -- requirements
Module: leb128_encoder

Interface
REQ-001 Parameter USE_64B, default 1, enables 64-bit operands; when 0, only 32-bit requests are legal.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  encode request present.
REQ-005 in_ready  output  1  encoder can accept a request.
REQ-006 in_data  input  64  operand; only bits [31:0] are used when in_is64=0.
REQ-007 in_signed  input  1  1 selects SLEB128, 0 selects ULEB128.
REQ-008 in_is64  input  1  1 selects 64-bit operand width, 0 selects 32-bit.
REQ-009 out_valid  output  1  out_byte is valid.
REQ-010 out_ready  input  1  consumer accepts out_byte.
REQ-011 out_byte  output  8  encoded byte; bit 7 is the continuation flag.
REQ-012 out_last  output  1  current out_byte is the final byte of the encoding.
REQ-013 out_index  output  4  zero-based position of out_byte within the encoding.
REQ-014 err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-015 The FSM shall have states IDLE and EMIT; in_ready shall be 1 only in IDLE.
REQ-016 A request is accepted on in_valid && in_ready; operand, signedness and width are latched in that cycle.
REQ-017 A 32-bit operand shall be latched sign-extended from bit 31 if in_signed=1, otherwise zero-extended; bits [63:32] of in_data are then ignored.
REQ-018 If in_is64=1 and USE_64B=0, the request shall be consumed, no bytes emitted, err pulsed for exactly one cycle, and the FSM shall stay in IDLE.
REQ-019 The first byte shall be valid the cycle after acceptance (latency 1); out_valid=1 throughout EMIT.
REQ-020 out_byte[6:0] shall equal the low 7 bits of the working register; out_byte[7] shall equal !out_last.
REQ-021 Unsigned termination: out_last=1 when (working register >> 7) == 0.
REQ-022 Signed termination: out_last=1 when the arithmetic shift (working register >>> 7) is all-zero with bit 6 = 0, or all-ones with bit 6 = 1.
REQ-023 On out_valid && out_ready && !out_last, the working register shall shift right by 7 (arithmetic if signed, logical if unsigned) and out_index shall increment.
REQ-024 While out_ready=0, out_byte, out_last and out_index shall hold stable.
REQ-025 On out_valid && out_ready && out_last, the FSM shall return to IDLE; in_ready shall be 1 the following cycle, with no same-cycle turnaround.
REQ-026 The maximum encoding length shall be 5 bytes for 32-bit and 10 bytes for 64-bit; out_index shall never exceed 4 or 9 respectively.

Reset
REQ-027 Reset shall put the FSM in IDLE with out_valid=0, out_last=0, out_index=0, out_byte=0, err=0, and in_ready=0 during the reset cycle.
REQ-028 Reset asserted mid-EMIT shall abandon the encoding, emit no further bytes, and raise in_ready on the first cycle after reset deasserts.

Structure
REQ-029 State encodings and the max-length constants (5 and 10) shall live in a shared header alongside cpu.vh definitions.
REQ-030 The block shall be a single module with no sub-modules; the termination check is a combinational function inside it.

Verification
REQ-031 ULEB 32-bit 624485 -> E5, 8E, 26; out_last only on 26; out_index 0..2.
REQ-032 SLEB 32-bit -123456 -> C0, BB, 78; SLEB 32-bit -1 -> single byte 7F; ULEB 0 -> single byte 00 with out_last=1.
REQ-033 ULEB 64-bit 0xFFFFFFFFFFFFFFFF -> nine FF bytes then 01; out_index reaches 9.
REQ-034 Backpressure: hold out_ready=0 for 3 cycles mid-encoding -> byte, out_last and out_index are unchanged, and the sequence resumes intact.
REQ-035 USE_64B=0 with in_is64=1 -> err high for 1 cycle, out_valid stays 0, in_ready stays 1.
REQ-036 Reset asserted after the 2nd byte of a 64-bit encoding -> out_valid=0 next cycle; a new request then encodes correctly from out_index 0.
